// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared AES definitions for the key-schedule controller and the
//   Key_Expansion round function: mode encodings, round counts, datapath
//   widths, the controller state type and a mode-to-round-count helper.
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int KEY_W  = 256;  // key input / expansion state width
  localparam int RK_W   = 128;  // one round key
  localparam int NR_MAX = 14;   // highest round index stored

  // Key mode encodings; any value with bit 1 set selects AES-256
  localparam logic [1:0] AES_128 = 2'b00;
  localparam logic [1:0] AES_192 = 2'b01;
  localparam logic [1:0] AES_256 = 2'b10;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  function automatic logic [3:0] nr_of(input logic [1:0] mode);
    case (mode)
      AES_128: return NR_128;
      AES_192: return NR_192;
      default: return NR_256;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_schedule_ctrl_key_expansion.sv
// ---------------------------------------------------------------------------
// Key_Expansion
//   Combinational AES key-expansion round. Given the expansion state and the
//   round index it returns round key i_Round_Times and the state for the
//   next index. The state is LSB-aligned like the cipher key, with the
//   oldest word in the most significant used position.
//   Ports:
//     i_Exp_Key     256  expansion state for this round index
//     i_Round_Times 4    round index 0..Nr
//     i_Key_Mode    2    00=AES-128, 01=AES-192, 1x=AES-256
//     o_Round_key   128  round key for i_Round_Times
//     o_Exp_key     256  expansion state for i_Round_Times+1
// ---------------------------------------------------------------------------
module Key_Expansion
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] i_Exp_Key,
  input  logic [3:0]       i_Round_Times,
  input  logic [1:0]       i_Key_Mode,
  output logic [RK_W-1:0]  o_Round_key,
  output logic [KEY_W-1:0] o_Exp_key
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [31:0]  rot_word;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [31:0]  temp_word;
  logic [3:0]   rcon_idx;
  logic [1:0]   phase_192;
  logic [3:0]   rcon_192;
  logic [191:0] src_w;
  logic [191:0] chain_w;
  logic [31:0]  prev_w;

  // The newest word always sits in the lowest 32 bits in every mode
  assign rot_word = {i_Exp_Key[23:0], i_Exp_Key[31:24]};

  // One SubWord per round index in every mode, so four S-boxes suffice
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      assign sub_out[gi*8 +: 8] = sbox(sub_in[gi*8 +: 8]);
    end
  endgenerate

  // AES-192: every third index only re-slices the current 6-word block;
  // the other two each generate the next block.
  always_comb begin
    phase_192 = 2'd0;
    rcon_192  = 4'd0;
    case (i_Round_Times)
      4'd1:    begin phase_192 = 2'd1; rcon_192 = 4'd1; end
      4'd2:    begin phase_192 = 2'd2; rcon_192 = 4'd2; end
      4'd4:    begin phase_192 = 2'd1; rcon_192 = 4'd3; end
      4'd5:    begin phase_192 = 2'd2; rcon_192 = 4'd4; end
      4'd7:    begin phase_192 = 2'd1; rcon_192 = 4'd5; end
      4'd8:    begin phase_192 = 2'd2; rcon_192 = 4'd6; end
      4'd10:   begin phase_192 = 2'd1; rcon_192 = 4'd7; end
      4'd11:   begin phase_192 = 2'd2; rcon_192 = 4'd8; end
      default: begin phase_192 = 2'd0; rcon_192 = 4'd0; end
    endcase
  end

  always_comb begin
    sub_in   = rot_word;
    rcon_idx = i_Round_Times + 4'd1;
    src_w    = {i_Exp_Key[127:0], 64'h0};
    case (i_Key_Mode)
      AES_128: begin
        sub_in   = rot_word;
        rcon_idx = i_Round_Times + 4'd1;
        src_w    = {i_Exp_Key[127:0], 64'h0};
      end
      AES_192: begin
        sub_in   = rot_word;
        rcon_idx = rcon_192;
        src_w    = i_Exp_Key[191:0];
      end
      default: begin
        // Odd indices produce w[i], i mod 8 == 4: SubWord without rotate/rcon
        sub_in   = i_Round_Times[0] ? i_Exp_Key[31:0] : rot_word;
        rcon_idx = i_Round_Times[0] ? 4'd0 : ({1'b0, i_Round_Times[3:1]} + 4'd1);
        src_w    = {i_Exp_Key[255:128], 64'h0};
      end
    endcase
  end

  assign temp_word = sub_out ^ {rcon(rcon_idx), 24'h0};

  // Chained XOR: each new word is the word Nk back xor the previous new word
  always_comb begin
    chain_w = '0;
    prev_w  = temp_word;
    for (int k = 0; k < 6; k++) begin
      prev_w = src_w[191-32*k -: 32] ^ prev_w;
      chain_w[191-32*k -: 32] = prev_w;
    end
  end

  always_comb begin
    o_Round_key = i_Exp_Key[127:0];
    o_Exp_key   = {128'h0, chain_w[191:64]};
    case (i_Key_Mode)
      AES_128: begin
        o_Round_key = i_Exp_Key[127:0];
        o_Exp_key   = {128'h0, chain_w[191:64]};
      end
      AES_192: begin
        case (phase_192)
          2'd1: begin
            o_Round_key = {i_Exp_Key[63:0], chain_w[191:128]};
            o_Exp_key   = {64'h0, chain_w};
          end
          2'd2: begin
            o_Round_key = i_Exp_Key[127:0];
            o_Exp_key   = {64'h0, chain_w};
          end
          default: begin
            o_Round_key = i_Exp_Key[191:64];
            o_Exp_key   = i_Exp_Key;
          end
        endcase
      end
      default: begin
        o_Round_key = i_Exp_Key[255:128];
        o_Exp_key   = {i_Exp_Key[127:0], chain_w[191:64]};
      end
    endcase
  end

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// ---------------------------------------------------------------------------
// aes_key_schedule_ctrl
//   Sequential AES key-schedule controller. On a start pulse it latches the
//   key and mode, steps Key_Expansion once per cycle, stores every round key
//   in a 15-entry file and serves the file by index with one cycle latency.
//   Ports:
//     i_Clk        clock, rising edge
//     i_Rst_n      asynchronous active-low reset
//     i_Key_Start  1-cycle start pulse (restarts from any state)
//     i_Key        256-bit LSB-aligned cipher key
//     i_Key_Mode   00=AES-128, 01=AES-192, 1x=AES-256
//     i_Rd_Idx     round-key read index
//     o_Rd_Key     registered round key for i_Rd_Idx (0 beyond Nr)
//     o_Key_Busy   expansion running
//     o_Key_Ready  all Nr+1 round keys valid
//     o_Nr         round count of the latched mode
// ---------------------------------------------------------------------------
module aes_key_schedule_ctrl
  import aes_pkg::*;
(
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Key_Start,
  input  logic [KEY_W-1:0] i_Key,
  input  logic [1:0]       i_Key_Mode,
  input  logic [3:0]       i_Rd_Idx,
  output logic [RK_W-1:0]  o_Rd_Key,
  output logic             o_Key_Busy,
  output logic             o_Key_Ready,
  output logic [3:0]       o_Nr
);

  state_t           state_q;
  logic [KEY_W-1:0] exp_key_q;
  logic [3:0]       round_q;
  logic [1:0]       mode_q;
  logic [3:0]       nr_q;
  logic             busy_q;
  logic             ready_q;
  logic [RK_W-1:0]  rd_key_q;
  logic [RK_W-1:0]  rk_q [NR_MAX+1];

  logic [RK_W-1:0]  round_key_d;
  logic [KEY_W-1:0] exp_key_d;
  logic [KEY_W-1:0] key_masked;

  Key_Expansion u_key_expansion (
    .i_Exp_Key     (exp_key_q),
    .i_Round_Times (round_q),
    .i_Key_Mode    (mode_q),
    .o_Round_key   (round_key_d),
    .o_Exp_key     (exp_key_d)
  );

  always_comb begin
    case (i_Key_Mode)
      AES_128: key_masked = {128'h0, i_Key[127:0]};
      AES_192: key_masked = {64'h0, i_Key[191:0]};
      default: key_masked = i_Key;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= IDLE;
      exp_key_q <= '0;
      round_q   <= '0;
      mode_q    <= '0;
      nr_q      <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      rd_key_q  <= '0;
      for (int k = 0; k <= NR_MAX; k++) rk_q[k] <= '0;
    end else begin
      // nr_q never exceeds NR_MAX, so the guard also keeps index 15 in range
      rd_key_q <= (i_Rd_Idx > nr_q) ? '0 : rk_q[i_Rd_Idx];

      if (i_Key_Start) begin
        state_q   <= EXPAND;
        exp_key_q <= key_masked;
        mode_q    <= i_Key_Mode;
        nr_q      <= nr_of(i_Key_Mode);
        round_q   <= '0;
        busy_q    <= 1'b1;
        ready_q   <= 1'b0;
      end else if (state_q == EXPAND) begin
        rk_q[round_q] <= round_key_d;
        exp_key_q     <= exp_key_d;
        if (round_q == nr_q) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end else begin
          round_q <= round_q + 4'd1;
        end
      end
    end
  end

  assign o_Rd_Key    = rd_key_q;
  assign o_Key_Busy  = busy_q;
  assign o_Key_Ready = ready_q;
  assign o_Nr        = nr_q;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
module tb_aes_key_schedule_ctrl;

  logic         clk;
  logic         rst_n;
  logic         key_start;
  logic [255:0] key;
  logic [1:0]   key_mode;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         key_busy;
  logic         key_ready;
  logic [3:0]   nr;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] KEY192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KEY256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] RK128 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  aes_key_schedule_ctrl dut (
    .i_Clk       (clk),
    .i_Rst_n     (rst_n),
    .i_Key_Start (key_start),
    .i_Key       (key),
    .i_Key_Mode  (key_mode),
    .i_Rd_Idx    (rd_idx),
    .o_Rd_Key    (rd_key),
    .o_Key_Busy  (key_busy),
    .o_Key_Ready (key_ready),
    .o_Nr        (nr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("  ok %s = %h", tag, got);
    end
  endtask

  task automatic start_only(input logic [255:0] k, input logic [1:0] m);
    @(negedge clk);
    key       = k;
    key_mode  = m;
    key_start = 1'b1;
    @(posedge clk);
    #1;
    key_start = 1'b0;
  endtask

  // Returns the number of edges after the start edge until Ready is seen
  task automatic run_key(input logic [255:0] k, input logic [1:0] m, output int edges);
    start_only(k, m);
    edges = 0;
    while (!key_ready && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic read_key(input logic [3:0] idx, output logic [127:0] val);
    @(negedge clk);
    rd_idx = idx;
    @(posedge clk);
    #1;
    val = rd_key;
  endtask

  initial begin
    int           edges;
    logic [127:0] val;
    logic [127:0] prev;

    rst_n     = 1'b0;
    key_start = 1'b0;
    key       = '0;
    key_mode  = 2'b00;
    rd_idx    = 4'd0;

    // Reset held; a start pulse during reset must be ignored
    repeat (2) @(posedge clk);
    @(negedge clk);
    key       = {128'h0, KEY128};
    key_start = 1'b1;
    @(posedge clk);
    #1;
    key_start = 1'b0;
    check_eq("rst_busy", 128'(key_busy), 128'd0);
    check_eq("rst_ready", 128'(key_ready), 128'd0);
    check_eq("rst_nr", 128'(nr), 128'd0);
    check_eq("rst_rdkey", rd_key, 128'h0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_busy", 128'(key_busy), 128'd0);
    check_eq("post_rst_ready", 128'(key_ready), 128'd0);
    check_eq("post_rst_nr", 128'(nr), 128'd0);
    check_eq("post_rst_rdkey", rd_key, 128'h0);

    // AES-128, upper key bits carry junk that must be ignored
    run_key({128'hdeadbeefcafef00d0123456789abcdef, KEY128}, 2'b00, edges);
    check_eq("edges128", 128'(edges), 128'd11);
    check_eq("nr128", 128'(nr), 128'd10);
    check_eq("busy128_done", 128'(key_busy), 128'd0);
    read_key(4'd0, val);  check_eq("rk128_0", val, RK128[0]);
    read_key(4'd1, val);  check_eq("rk128_1", val, RK128[1]);
    read_key(4'd10, val); check_eq("rk128_10", val, RK128[10]);

    // Sweep 10..0: output holds until the edge after the index changes
    prev = RK128[10];
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      rd_idx = 4'(i);
      #1;
      check_eq($sformatf("hold_before_rk%0d", i), rd_key, prev);
      @(posedge clk);
      #1;
      check_eq($sformatf("sweep_rk%0d", i), rd_key, RK128[i]);
      prev = RK128[i];
    end
    read_key(4'd11, val); check_eq("rk128_idx11", val, 128'h0);
    read_key(4'd15, val); check_eq("rk128_idx15", val, 128'h0);

    // AES-192
    run_key({64'hffffffffffffffff, KEY192}, 2'b01, edges);
    check_eq("edges192", 128'(edges), 128'd13);
    check_eq("nr192", 128'(nr), 128'd12);
    read_key(4'd0, val);  check_eq("rk192_0", val, 128'h8e73b0f7da0e6452c810f32b809079e5);
    read_key(4'd1, val);  check_eq("rk192_1", val, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    read_key(4'd12, val); check_eq("rk192_12", val, 128'he98ba06f448c773c8ecc720401002202);
    read_key(4'd13, val); check_eq("rk192_idx13", val, 128'h0);

    // AES-256 via mode 2'b11
    run_key(KEY256, 2'b11, edges);
    check_eq("edges256", 128'(edges), 128'd15);
    check_eq("nr256", 128'(nr), 128'd14);
    read_key(4'd0, val);  check_eq("rk256_0", val, 128'h603deb1015ca71be2b73aef0857d7781);
    read_key(4'd1, val);  check_eq("rk256_1", val, 128'h1f352c073b6108d72d9810a30914dff4);
    read_key(4'd2, val);  check_eq("rk256_2", val, 128'h9ba354118e6925afa51a8b5f2067fcde);
    read_key(4'd14, val); check_eq("rk256_14", val, 128'hfe4890d1e6188d0b046df344706c631e);
    read_key(4'd15, val); check_eq("rk256_idx15", val, 128'h0);

    // Restart during AES-256 round 5 with the AES-128 key
    start_only(KEY256, 2'b10);
    check_eq("restart_ready_drop", 128'(key_ready), 128'd0);
    check_eq("restart_busy", 128'(key_busy), 128'd1);
    repeat (5) @(posedge clk);
    run_key({128'h0, KEY128}, 2'b00, edges);
    check_eq("edges_restart", 128'(edges), 128'd11);
    check_eq("nr_restart", 128'(nr), 128'd10);
    read_key(4'd0, val);  check_eq("restart_rk0", val, RK128[0]);
    read_key(4'd5, val);  check_eq("restart_rk5", val, RK128[5]);
    read_key(4'd10, val); check_eq("restart_rk10", val, RK128[10]);
    read_key(4'd12, val); check_eq("restart_idx12", val, 128'h0);

    // Asynchronous reset in the middle of an expansion
    @(negedge clk);
    rd_idx = 4'd0;
    start_only({128'h0, KEY128}, 2'b00);
    repeat (3) @(posedge clk);
    #3;
    check_eq("midexp_busy", 128'(key_busy), 128'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_busy", 128'(key_busy), 128'd0);
    check_eq("async_ready", 128'(key_ready), 128'd0);
    check_eq("async_nr", 128'(nr), 128'd0);
    check_eq("async_rdkey", rd_key, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    read_key(4'd0, val);
    check_eq("cleared_rk0", val, 128'h0);
    repeat (12) @(posedge clk);
    #1;
    check_eq("no_partial_ready", 128'(key_ready), 128'd0);
    check_eq("idle_busy", 128'(key_busy), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
